// File: rtl/psram_line_reader_if.sv
// ----------------------------------------------------------------------------
// psram_line_reader_if
//   Bundles the two streaming sides of the PSRAM line reader:
//     - arbiter read port : o_read_req, o_read_addr, i_read_gnt,
//                           i_read_data, i_read_data_valid
//     - pixel stream      : o_pix_data, o_pix_valid, i_pix_ready
//   Signal names keep the reader's point of view (o_ = driven by the reader).
//   modport master : the line reader itself
//   modport slave  : the arbiter / pixel pipeline side
// ----------------------------------------------------------------------------
interface psram_line_reader_if;
    logic        o_read_req;
    logic [20:0] o_read_addr;
    logic        i_read_gnt;
    logic [63:0] i_read_data;
    logic        i_read_data_valid;
    logic [63:0] o_pix_data;
    logic        o_pix_valid;
    logic        i_pix_ready;

    modport master (
        output o_read_req, o_read_addr, o_pix_data, o_pix_valid,
        input  i_read_gnt, i_read_data, i_read_data_valid, i_pix_ready
    );

    modport slave (
        input  o_read_req, o_read_addr, o_pix_data, o_pix_valid,
        output i_read_gnt, i_read_data, i_read_data_valid, i_pix_ready
    );
endinterface

// File: rtl/psram_line_reader.sv
// ----------------------------------------------------------------------------
// psram_line_reader
//   Fetches one display line from the PSRAM framebuffer as LINE_BURSTS
//   fixed-length bursts of BEATS 64-bit beats and hands the beats to the
//   HDMI pixel pipeline through a first-word-fall-through FIFO.
//   A burst is requested only when the FIFO has room for all of it, so the
//   PSRAM data path never needs back-pressure.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_line_start        one-cycle pulse, start fetching line i_line_idx
//   i_line_idx[9:0]     line number, sampled with i_line_start
//   i_flush             empties the FIFO (FSM unaffected)
//   o_busy              a line fetch is in progress
//   o_line_done         pulse: last beat of the line was pushed
//   o_err               pulse: fetch aborted on data timeout
//   bus (master)        arbiter read port and pixel stream, see the interface
// ----------------------------------------------------------------------------
module psram_line_reader #(
    parameter int BEATS       = 4,
    parameter int LINE_BURSTS = 60,
    parameter int ADDR_STEP   = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_line_start,
    input  logic [9:0]                 i_line_idx,
    input  logic                       i_flush,
    output logic                       o_busy,
    output logic                       o_line_done,
    output logic                       o_err,
    psram_line_reader_if.master        bus
);

    localparam int unsigned LINE_STRIDE = LINE_BURSTS * ADDR_STEP;
    localparam int AW  = (FIFO_DEPTH > 1)  ? $clog2(FIFO_DEPTH)  : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int BCW = (LINE_BURSTS > 1) ? $clog2(LINE_BURSTS) : 1;
    localparam int BTW = (BEATS > 1)       ? $clog2(BEATS)       : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT
    } state_e;

    state_e           state_q;
    logic             req_q;
    logic [20:0]      addr_q;
    logic [BCW-1:0]   burst_q;
    logic [BTW-1:0]   beat_q;
    logic [7:0]       tmo_q;
    logic             done_q;
    logic             err_q;

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    logic [20:0]      base_d;
    logic             push;
    logic             pop;
    logic             room_ok;

    // Line base address; the 32-bit product is wider than needed, and the
    // cast keeps the low 21 bits so the address wraps modulo 2^21.
    assign base_d  = 21'(32'(i_line_idx) * LINE_STRIDE);

    // Beats are only accepted while a granted burst is outstanding.
    assign push    = (state_q == S_WAIT) && bus.i_read_data_valid;
    assign pop     = (count_q != '0) && bus.i_pix_ready;
    assign room_ok = (count_q <= CW'(FIFO_DEPTH - BEATS));

    assign o_busy          = (state_q != S_IDLE);
    assign o_line_done     = done_q;
    assign o_err           = err_q;
    assign bus.o_read_req  = req_q;
    assign bus.o_read_addr = addr_q;
    assign bus.o_pix_data  = mem_q[rptr_q];
    assign bus.o_pix_valid = (count_q != '0);

    // Fetch sequencer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_line_start) begin
                        addr_q  <= base_d;
                        burst_q <= '0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (room_ok) begin
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.i_read_gnt) begin
                        req_q   <= 1'b0;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_read_data_valid) begin
                        tmo_q <= '0;
                        if (beat_q == BTW'(BEATS - 1)) begin
                            beat_q <= '0;
                            if (burst_q == BCW'(LINE_BURSTS - 1)) begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                addr_q  <= addr_q + 21'(ADDR_STEP);
                                burst_q <= burst_q + BCW'(1);
                                state_q <= S_CHECK;
                            end
                        end else begin
                            beat_q <= beat_q + BTW'(1);
                        end
                    end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                        // Counter would reach TIMEOUT this cycle: abort,
                        // leaving whatever already landed in the FIFO.
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            mem_q[wptr_q] <= bus.i_read_data;
        end
    end

    // FIFO pointers and occupancy; flush wins over a same-cycle push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_psram_line_reader.sv
// ----------------------------------------------------------------------------
// tb_psram_line_reader
//   Self-checking bench for psram_line_reader. The bench plays the arbiter
//   and PSRAM (grants and random data beats) and the pixel consumer.
//   Reference model: a queue of the beats the reader must deliver, plus
//   expected burst addresses computed as base + burst * ADDR_STEP.
// ----------------------------------------------------------------------------
module tb_psram_line_reader;

    localparam int BEATS = 4;
    localparam int LB    = 8;
    localparam int STEP  = 16;
    localparam int DEPTH = 16;
    localparam int TMO   = 255;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_line_start = 1'b0;
    logic [9:0] i_line_idx = '0;
    logic       i_flush = 1'b0;
    logic       o_busy;
    logic       o_line_done;
    logic       o_err;

    psram_line_reader_if bus ();

    psram_line_reader #(
        .BEATS       (BEATS),
        .LINE_BURSTS (LB),
        .ADDR_STEP   (STEP),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_line_start (i_line_start),
        .i_line_idx   (i_line_idx),
        .i_flush      (i_flush),
        .o_busy       (o_busy),
        .o_line_done  (o_line_done),
        .o_err        (o_err),
        .bus          (bus.master)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [9:0]  idx;
        int          gdly;
        bit          poke;
        bit          flush;
        bit          rr;
        logic [20:0] exp_base;
    } line_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_q [$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event counters and pixel consumer check, sampled on the falling edge
    always @(negedge i_clk) begin
        if (o_line_done === 1'b1) done_cnt++;
        if (o_err === 1'b1) err_cnt++;
        if (bus.o_read_req && !req_prev) req_rises++;
        req_prev = bus.o_read_req;
        if (!i_rst && bus.o_pix_valid && bus.i_pix_ready) begin
            if (model_q.size() == 0) chk("pix_unexpected", 64'(bus.o_pix_valid), 64'd0);
            else chk("pix_data", bus.o_pix_data, model_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_ready) bus.i_pix_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (bus.o_read_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("req_timeout", 64'(bus.o_read_req), 64'd1);
    endtask

    task automatic beat(input bit expect_kept);
        logic [63:0] d;
        d = {$urandom, $urandom};
        bus.i_read_data = d;
        bus.i_read_data_valid = 1'b1;
        if (expect_kept) model_q.push_back(d);
        tick();
        bus.i_read_data_valid = 1'b0;
    endtask

    task automatic serve_burst(input logic [20:0] exp_addr, input int gdly,
                               input int nbeats, input bit flush_mid);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        chk("req_addr", 64'(bus.o_read_addr), 64'(exp_addr));
        for (int k = 0; k < gdly; k++) begin
            tick();
            chk("req_hold", 64'(bus.o_read_req), 64'd1);
            chk("addr_hold", 64'(bus.o_read_addr), 64'(exp_addr));
        end
        bus.i_read_gnt = 1'b1;
        tick();
        bus.i_read_gnt = 1'b0;
        chk("req_drop", 64'(bus.o_read_req), 64'd0);
        for (int j = 0; j < nbeats; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            beat(1'b1);
            if (flush_mid && j == 0) begin
                i_flush = 1'b1;
                tick();
                i_flush = 1'b0;
                model_q.delete();
                chk("flush_empty", 64'(bus.o_pix_valid), 64'd0);
            end
        end
    endtask

    task automatic start_line(input logic [9:0] idx);
        i_line_idx = idx;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        i_line_idx = 10'($urandom);
        chk("busy_start", 64'(o_busy), 64'd1);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        bus.i_pix_ready = 1'b1;
        for (int n = 0; n < 300 && (model_q.size() != 0 || bus.o_pix_valid); n++) tick();
        chk("drain_valid", 64'(bus.o_pix_valid), 64'd0);
        chk("drain_model", 64'(model_q.size()), 64'd0);
    endtask

    task automatic finish_line(input logic [20:0] base, input int first, input int gdly,
                               input bit poke, input bit flush);
        for (int b = first; b < LB; b++) begin
            serve_burst(21'(base + 21'(b * STEP)), gdly, BEATS, flush && b == 1);
            if (b == LB - 1) begin
                chk("line_done", 64'(o_line_done), 64'd1);
                chk("busy_end", 64'(o_busy), 64'd0);
            end else begin
                chk("line_done_early", 64'(o_line_done), 64'd0);
                chk("busy_mid", 64'(o_busy), 64'd1);
            end
            if (poke && b == 0) begin
                i_line_idx = 10'($urandom) ^ 10'h155;
                i_line_start = 1'b1;
                tick();
                i_line_start = 1'b0;
            end
        end
        tick();
        chk("line_done_pulse", 64'(o_line_done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_vec_t vecs [5];
        int d0, r0, e0, n;

        vecs[0] = '{idx: 10'd3,    gdly: 2,  poke: 0, flush: 0, rr: 0, exp_base: 21'd384};
        vecs[1] = '{idx: 10'd0,    gdly: 0,  poke: 0, flush: 0, rr: 1, exp_base: 21'd0};
        vecs[2] = '{idx: 10'd1023, gdly: 1,  poke: 1, flush: 0, rr: 1, exp_base: 21'd130944};
        vecs[3] = '{idx: 10'd517,  gdly: 3,  poke: 0, flush: 1, rr: 1, exp_base: 21'd66176};
        vecs[4] = '{idx: 10'd7,    gdly: 50, poke: 0, flush: 0, rr: 1, exp_base: 21'd896};

        bus.i_read_gnt = 1'b0;
        bus.i_read_data = '0;
        bus.i_read_data_valid = 1'b0;
        bus.i_pix_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_req", 64'(bus.o_read_req), 64'd0);
        chk("rst_addr", 64'(bus.o_read_addr), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_line_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_pix_valid", 64'(bus.o_pix_valid), 64'd0);
        i_rst = 1'b0;
        tick();

        // A beat in IDLE is discarded
        beat(1'b0);
        chk("idle_beat_drop", 64'(bus.o_pix_valid), 64'd0);

        // Whole lines from the vector table
        for (int v = 0; v < 5; v++) begin
            rand_ready = vecs[v].rr;
            bus.i_pix_ready = 1'b1;
            d0 = done_cnt;
            r0 = req_rises;
            start_line(vecs[v].idx);
            finish_line(vecs[v].exp_base, 0, vecs[v].gdly, vecs[v].poke, vecs[v].flush);
            chk("done_count", 64'(done_cnt - d0), 64'd1);
            chk("req_per_line", 64'(req_rises - r0), 64'(LB));
            drain();
        end

        // Back-pressure: FIFO fills after four bursts, fifth waits for room
        rand_ready = 1'b0;
        bus.i_pix_ready = 1'b0;
        r0 = req_rises;
        start_line(10'd5);
        for (int b = 0; b < 4; b++) serve_burst(21'(640 + b * STEP), 0, BEATS, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.o_read_req) chk("stall_noreq", 64'(bus.o_read_req), 64'd0);
        end
        chk("stall_req_count", 64'(req_rises - r0), 64'd4);
        chk("stall_busy", 64'(o_busy), 64'd1);
        bus.i_pix_ready = 1'b1;
        repeat (4) tick();
        bus.i_pix_ready = 1'b0;
        rand_ready = 1'b1;
        finish_line(21'd640, 4, 0, 1'b0, 1'b0);
        chk("bp_req_count", 64'(req_rises - r0), 64'(LB));
        drain();

        // Timeout after two of four beats
        bus.i_pix_ready = 1'b0;
        e0 = err_cnt;
        start_line(10'd9);
        serve_burst(21'd1152, 0, 2, 1'b0);
        n = 0;
        while (!o_err && n < 400) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
        chk("tmo_busy", 64'(o_busy), 64'd0);
        tick();
        chk("tmo_err_pulse", 64'(o_err), 64'd0);
        chk("tmo_err_count", 64'(err_cnt - e0), 64'd1);
        chk("tmo_fifo_kept", 64'(bus.o_pix_valid), 64'd1);
        bus.i_pix_ready = 1'b1;
        repeat (2) tick();
        bus.i_pix_ready = 1'b0;
        chk("tmo_fifo_two", 64'(bus.o_pix_valid), 64'd0);
        chk("tmo_model_two", 64'(model_q.size()), 64'd0);
        rand_ready = 1'b1;
        start_line(10'd2);
        finish_line(21'd256, 0, 1, 1'b0, 1'b0);
        drain();

        // Reset in WAIT after one beat
        bus.i_pix_ready = 1'b0;
        start_line(10'd4);
        serve_burst(21'd512, 0, 1, 1'b0);
        i_rst = 1'b1;
        tick();
        chk("mid_rst_req", 64'(bus.o_read_req), 64'd0);
        chk("mid_rst_addr", 64'(bus.o_read_addr), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_done", 64'(o_line_done), 64'd0);
        chk("mid_rst_err", 64'(o_err), 64'd0);
        chk("mid_rst_pix_valid", 64'(bus.o_pix_valid), 64'd0);
        i_rst = 1'b0;
        model_q.delete();
        for (int j = 0; j < 3; j++) beat(1'b0);
        tick();
        chk("post_rst_drop", 64'(bus.o_pix_valid), 64'd0);
        chk("post_rst_busy", 64'(o_busy), 64'd0);
        bus.i_pix_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_line_reader.md
Name: psram_line_reader

Overview:
- Read-side client of the PSRAM arbiter read port; fetches one display line from the PSRAM framebuffer as a sequence of fixed-length bursts.
- Delivers the returned 64-bit beats to the HDMI pixel pipeline through an internal first-word-fall-through FIFO with valid/ready.
- Issues a burst request only when the FIFO can absorb the whole burst. No back-pressure on the PSRAM data path is ever needed.

Parameters:
- BEATS, 4: 64-bit data beats returned per granted read.
- LINE_BURSTS, 60: bursts per display line.
- ADDR_STEP, 16: PSRAM address increment per burst.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of two and >= BEATS.
- TIMEOUT, 255: cycles without a data beat in WAIT before the fetch is aborted (8-bit counter).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_line_start  in  1  one-cycle pulse; start fetching line i_line_idx
- i_line_idx  in  10  line number; sampled on i_line_start
- i_flush  in  1  empties the FIFO
- o_busy  out  1  a line fetch is in progress
- o_line_done  out  1  one-cycle pulse when the last beat of the line is pushed
- o_err  out  1  one-cycle pulse on timeout abort
- o_read_req  out  1  request to arbiter
- i_read_gnt  in  1  one-cycle grant from arbiter
- o_read_addr  out  21  burst address; stable while o_read_req is high
- i_read_data  in  64  read data
- i_read_data_valid  in  1  read data beat strobe
- o_pix_data  out  64  FIFO head
- o_pix_valid  out  1  FIFO not empty
- i_pix_ready  in  1  consumer accepts head when valid & ready

Behaviour:
- Clock, reset, and output reset values:
  - One clock domain. Reset is synchronous and active-high: i_clk / i_rst.
  - Reset values: o_read_req=0, o_read_addr=0, o_busy=0, o_line_done=0, o_err=0, o_pix_valid=0, FIFO empty, state IDLE, all counters 0.
  - Reset asserted mid-burst abandons the burst. Beats arriving after reset deassertion while in IDLE are dropped.
- States: IDLE, CHECK, REQ, WAIT. o_busy=1 in every state except IDLE.
- IDLE:
  - On i_line_start, latch base = i_line_idx * LINE_BURSTS * ADDR_STEP, truncated to 21 bits (wraps modulo 2^21).
  - Set o_read_addr=base and burst_cnt=0, then go to CHECK.
  - i_line_start is ignored in all other states.
- CHECK: if (FIFO_DEPTH - count) >= BEATS, go to REQ next cycle; otherwise stay.
- REQ:
  - o_read_req=1 with o_read_addr held.
  - When i_read_gnt is seen: o_read_req=0 in the following cycle, clear beat_cnt and timeout counter, go to WAIT.
  - Requests are never withdrawn before grant.
- WAIT:
  - Each i_read_data_valid pushes i_read_data into the FIFO, increments beat_cnt, and clears the timeout counter.
  - On the BEATS-th beat:
    - If burst_cnt == LINE_BURSTS-1: pulse o_line_done in the next cycle and go to IDLE.
    - Else: o_read_addr += ADDR_STEP (21-bit wrap), burst_cnt++, go to CHECK.
  - Without a beat, the timeout counter increments. On reaching TIMEOUT: pulse o_err, go to IDLE, keep the FIFO contents.
- Beats outside WAIT are discarded.
- At most one request is outstanding at a time.
- FIFO:
  - o_pix_data/o_pix_valid reflect the head combinationally from registered storage.
  - A simultaneous push and pop leaves count unchanged.
  - Overflow cannot occur because of the CHECK rule. A push into a full FIFO is an assertion failure in simulation.
  - A pop when empty has no effect.
- i_flush:
  - Sets count and both pointers to 0 in the next cycle, overriding any same-cycle push/pop.
  - Does not affect the FSM. If asserted in WAIT, later beats of that burst are still pushed.

Test Plan:
- LINE_BURSTS=2, i_line_idx=3, i_pix_ready=1, grant 2 cycles after req -> o_read_addr=96 then 112; 8 beats appear in order on o_pix_data; o_line_done pulses once; o_busy falls on the same cycle.
- i_pix_ready=0, FIFO_DEPTH=16, BEATS=4, LINE_BURSTS=8 -> exactly 4 bursts issued, then held in CHECK with o_read_req=0; raising i_pix_ready for 4 pops -> 5th request issued.
- Grant withheld 50 cycles -> o_read_req and o_read_addr stable all 50 cycles; o_read_req drops the cycle after i_read_gnt; exactly one request per grant.
- Grant given, then only 2 of 4 beats delivered -> o_err pulses TIMEOUT cycles after the 2nd beat; state IDLE; FIFO holds 2 entries; a new i_line_start is accepted.
- i_line_start pulsed while busy with a different idx -> ignored; address sequence unchanged.
- i_rst asserted in WAIT after 1 beat -> all outputs at reset values next cycle; the remaining 3 beats are dropped; FIFO empty.
